// File: rtl/bcd_display_scan.sv
// Six-digit packed-BCD display scanner: shadow capture on LOAD, time-multiplexed
// seven-segment output with dead cycle, leading-zero blanking and error dash.
module bcd_display_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        CLK,
    input  logic        CLR_N,
    input  logic        LOAD,
    input  logic [23:0] BCD_IN,
    input  logic        BLANK_EN,
    output logic [6:0]  SEG,
    output logic [5:0]  DIG
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [23:0]      shadow_q, shadow_d;
    logic [6:0]       seg_q, seg_d;
    logic [5:0]       dig_q, dig_d;

    logic             cnt_wrap;
    logic [5:0]       upper_zero;
    logic [3:0]       nib;
    logic             blank;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == 3'd5) ? '0 : idx_q + 3'd1;
        end
        shadow_d = LOAD ? BCD_IN : shadow_q;

        // upper_zero[i]: nibbles i..5 of the shadow are all zero
        for (int unsigned i = 0; i < 6; i++) begin
            upper_zero[i] = ((shadow_q >> (4 * i)) == '0);
        end

        nib   = '0;
        blank = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) begin
                nib   = shadow_q[4*i +: 4];
                blank = BLANK_EN && (i != 0) && upper_zero[i];
            end
        end

        dig_d = '1;
        seg_d = '0;
        if (cnt_q != '0) begin
            dig_d = ~(6'b000001 << idx_q);
            if (!blank) begin
                seg_d = glyph(nib);
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            seg_q    <= '0;
            dig_q    <= '1;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
        end
    end

    assign SEG = seg_q;
    assign DIG = dig_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized self-checking bench for bcd_display_scan against a slot/arithmetic
// model, plus literal per-digit scan tables.
module tb_bcd_display_scan;

    localparam int unsigned SD = 4;

    logic        CLK = 1'b0;
    logic        CLR_N;
    logic        LOAD;
    logic [23:0] BCD_IN;
    logic        BLANK_EN;
    logic [6:0]  SEG;
    logic [5:0]  DIG;

    int unsigned errors = 0;
    int unsigned checks = 0;

    int unsigned n = 0;          // edges since reset release
    logic [23:0] mshadow = '0;
    logic [23:0] bcd_drv = '0;

    logic [6:0] gly [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    bcd_display_scan #(.SCAN_DIV(SD)) dut (
        .CLK      (CLK),
        .CLR_N    (CLR_N),
        .LOAD     (LOAD),
        .BCD_IN   (BCD_IN),
        .BLANK_EN (BLANK_EN),
        .SEG      (SEG),
        .DIG      (DIG)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %02h expected %02h", nm, $time, act, exp);
        end
    endtask

    // Output produced by the edge whose pre-edge slot position is edge count k
    function automatic void model(input int unsigned k, input logic [23:0] sh, input logic ben,
                                  output logic [6:0] s, output logic [5:0] d);
        int unsigned c;
        int unsigned i;
        logic [23:0] up;
        c  = k % SD;
        i  = (k / SD) % 6;
        up = sh >> (4 * i);
        if (c == 0) begin
            s = 7'h00;
            d = 6'h3F;
        end else begin
            d = 6'h3F ^ (6'd1 << i);
            s = gly[up[3:0]];
            if (ben && i > 0 && up == 24'h0) s = 7'h00;
        end
    endfunction

    task automatic cycle(input logic ld, input logic [23:0] bcd);
        logic [6:0] es;
        logic [5:0] ed;
        LOAD   = ld;
        BCD_IN = bcd;
        model(n, mshadow, BLANK_EN, es, ed);
        @(posedge CLK);
        if (ld) mshadow = bcd;
        n++;
        #1;
        chk("seg_model", {1'b0, SEG}, {1'b0, es});
        chk("dig_model", {2'b0, DIG}, {2'b0, ed});
    endtask

    // One whole scan from slot 0, compared against literal per-digit glyphs {d5..d0}
    task automatic scan_lit(input string nm, input logic [41:0] segs);
        logic [35:0] digs;
        int unsigned c;
        int unsigned i;
        digs = {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};
        while (n % 24 != 0) cycle(1'b0, bcd_drv);
        for (int unsigned k = 0; k < 24; k++) begin
            cycle(1'b0, bcd_drv);
            c = k % SD;
            i = k / SD;
            if (c == 0) begin
                chk({nm, "_dead_seg"}, {1'b0, SEG}, 8'h00);
                chk({nm, "_dead_dig"}, {2'b0, DIG}, 8'h3F);
            end else begin
                chk({nm, "_seg"}, {1'b0, SEG}, {1'b0, segs[7*i +: 7]});
                chk({nm, "_dig"}, {2'b0, DIG}, {2'b0, digs[6*i +: 6]});
            end
        end
    endtask

    initial begin
        logic [23:0] r;
        CLR_N    = 1'b0;
        LOAD     = 1'b0;
        BCD_IN   = '0;
        BLANK_EN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_seg", {1'b0, SEG}, 8'h00);
        chk("reset_dig", {2'b0, DIG}, 8'h3F);
        CLR_N = 1'b1;
        n = 0;
        mshadow = '0;

        // Full scan, no blanking
        bcd_drv = 24'h123456;
        cycle(1'b1, bcd_drv);
        chk("first_edge_dead", {2'b0, DIG}, 8'h3F);
        scan_lit("full", {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D});

        // Leading-zero blanking
        BLANK_EN = 1'b1;
        bcd_drv  = 24'h000120;
        cycle(1'b1, bcd_drv);
        scan_lit("blank120", {7'h00, 7'h00, 7'h00, 7'h06, 7'h5B, 7'h3F});
        bcd_drv = 24'h000000;
        cycle(1'b1, bcd_drv);
        scan_lit("blank0", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F});

        // Invalid nibble counts as non-zero
        bcd_drv = 24'h00A009;
        cycle(1'b1, bcd_drv);
        scan_lit("invalid", {7'h00, 7'h00, 7'h40, 7'h3F, 7'h3F, 7'h6F});

        // Hold without LOAD, then single load
        cycle(1'b1, 24'h000007);
        bcd_drv = 24'h999999;
        scan_lit("hold", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h07});
        cycle(1'b1, bcd_drv);
        scan_lit("reload", {6{7'h6F}});

        // 100 scan periods of random loads, data and blanking
        for (int unsigned k = 0; k < 2400; k++) begin
            int unsigned z;
            if ($urandom_range(0, 63) == 0) BLANK_EN = 1'($urandom_range(0, 1));
            z = $urandom_range(0, 6);
            for (int unsigned j = 0; j < 6; j++) begin
                if (j >= 6 - z) r[4*j +: 4] = 4'h0;
                else if ($urandom_range(0, 7) == 0) r[4*j +: 4] = 4'($urandom_range(10, 15));
                else r[4*j +: 4] = 4'($urandom_range(0, 9));
            end
            bcd_drv = r;
            cycle($urandom_range(0, 7) == 0, bcd_drv);
        end

        // Asynchronous reset while digit 3 is lit
        while (n % 24 != 15) cycle(1'b0, bcd_drv);
        chk("pre_reset_dig3", {2'b0, DIG}, 8'h37);
        #2;
        CLR_N = 1'b0;
        #1;
        chk("async_reset_seg", {1'b0, SEG}, 8'h00);
        chk("async_reset_dig", {2'b0, DIG}, 8'h3F);
        CLR_N = 1'b1;
        n = 0;
        mshadow = '0;
        cycle(1'b0, bcd_drv);
        chk("post_reset_dead", {2'b0, DIG}, 8'h3F);
        for (int unsigned k = 0; k < 3; k++) begin
            cycle(1'b0, bcd_drv);
            chk("post_reset_dig0", {2'b0, DIG}, 8'h3E);
            chk("post_reset_seg0", {1'b0, SEG}, 8'h3F);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Display-side consumer of the 6-digit packed-BCD count word produced by the team's frequency/event counters. Captures the 24-bit BCD value on a load strobe into a shadow register. Time-multiplexes the six digits onto one seven-segment bus with digit strobes, optional leading-zero blanking, inter-digit dead time and an error glyph for non-decimal nibbles. Sits between the counter's `Q` output and the board's multiplexed LED display.

## Interface
- `SCAN_DIV`, default 50000: CLK cycles per digit slot; legal range ≥ 2.
- `CLK` input 1: system clock; all state updates on the rising edge.
- `CLR_N` input 1: reset, asynchronous, active-low.
- `LOAD` input 1: capture strobe, sampled on each CLK edge.
- `BCD_IN` input 24: packed BCD. Nibble 0 = `[3:0]` is the least significant digit; nibble 5 = `[23:20]`.
- `BLANK_EN` input 1: 1 enables leading-zero blanking.
- `SEG` output 7: segments `{g,f,e,d,c,b,a}`, active-high, registered.
- `DIG` output 6: digit enables, active-low, one-hot-low when active, registered. `DIG[i]` drives digit i.

## Operation
- **Shadow register:** `shadow <= BCD_IN` on any edge with `LOAD`=1. Otherwise it holds. The display reads `shadow` only, so `BCD_IN` changes without `LOAD` have no effect. `LOAD` held high makes the shadow track `BCD_IN` with one-cycle delay.
- **Prescaler:** `cnt` runs 0..`SCAN_DIV`-1. At `SCAN_DIV`-1 it wraps to 0, and `idx` advances 0→1→…→5→0. No other event alters `cnt` or `idx` except reset.
- **Per-edge output update:**
  - `DIG`/`SEG` are computed from the pre-edge `cnt`, `idx` and `shadow`.
  - If `cnt`==0 (dead cycle): `DIG`=6'h3F and `SEG`=7'h00.
  - Otherwise `DIG` is 6'h3F with bit `idx` cleared, and `SEG`=glyph(nibble `idx` of `shadow`).
- **Glyphs:** 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F. Nibbles A–F give 40 (dash).
- **Blanking:** digit i≥1 is blanked when `BLANK_EN`=1 and nibbles i..5 of `shadow` are all zero.
  - A blanked digit has `SEG`=7'h00, with its `DIG` bit still asserted so slot timing is unchanged.
  - Digit 0 is never blanked.
  - Invalid nibbles count as non-zero.
- **Reset (`CLR_N`=0):** `cnt`=0, `idx`=0, `shadow`=0, `SEG`=7'h00, `DIG`=6'h3F, all immediately and independent of CLK. This holds for reset asserted mid-slot or mid-load.

## Timing
- Scan period is 6×`SCAN_DIV` cycles.
- Each digit is lit for `SCAN_DIV`-1 consecutive cycles, separated by exactly one all-off cycle.
- Output lags internal state by one cycle. After reset release, the first edge outputs the dead cycle, and digit 0 lights from the second edge.
- `LOAD` at edge k updates `shadow` at k. `SEG` reflects the new value from edge k+1 for whichever digit is active.
- A `LOAD` during a lit slot changes `SEG` mid-slot; no glitch suppression is required.
- `SCAN_DIV`=2 gives one lit cycle and one dead cycle per digit.

## Test plan
(All with `SCAN_DIV`=4.)
- **Reset:** drive `CLR_N` low mid-scan with digit 3 lit → `DIG`=3F and `SEG`=00 before the next CLK edge. After release: one dead cycle, then `DIG`=3E for 3 cycles.
- **Full scan:** load 24'h123456 with `BLANK_EN`=0 → `SEG` sequence 7D, 6D, 66, 4F, 5B, 06 with `DIG` 3E, 3D, 3B, 37, 2F, 1F. Each digit lasts 3 cycles with a 3F/00 cycle between digits; the period is 24 cycles.
- **Blanking:** load 24'h000120 with `BLANK_EN`=1 → digits 0..2 show 3F, 5B, 06 and digits 3..5 show `SEG`=00 with `DIG` still strobed. Load 24'h000000 → digit 0 shows 3F and all other digits 00.
- **Invalid nibble:** load 24'h00A009 with `BLANK_EN`=1 → digit 0 shows 6F, digits 1 and 2 show 3F, digit 3 shows 40, digits 4 and 5 show 00.
- **Hold without LOAD:** shadow holds 24'h000007 while `BCD_IN` changes to 24'h999999 with `LOAD`=0 for a full scan → digit 0 remains 07. A single-cycle `LOAD` then gives 6F on all digits from the next edge.
- **Wrap:** run 100 scan periods → `idx` returns to 0 after digit 5 with no skipped or doubled slot. Every period is exactly 24 cycles.
